fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the 5-stage pipeline. It owns the program counter, issues in-order word requests to instruction memory over a request/grant/response handshake, and buffers returned words in a small FIFO. It presents one instruction per cycle to the decode/control stage on `d_inst_o`, and honours that stage's `incr_pc` stall by holding the presented instruction. A redirect port flushes in-flight fetches for future branch/jump support.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries; power of two, ≥2.

- `clk_i` input 1: clock.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `incr_pc_i` input 1: from control; 1 = decode consumes `d_inst_o` this cycle, 0 = hold.
- `redirect_i` input 1: flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i` input 32: new PC; bits [1:0] ignored and treated as 0.
- `imem_req_o` output 1: fetch request valid.
- `imem_addr_o` output 32: word-aligned fetch address.
- `imem_gnt_i` input 1: request accepted this cycle.
- `imem_rvalid_i` input 1: response data valid; responses return in order, at least 1 cycle after grant.
- `imem_rdata_i` input 32: instruction word.
- `d_inst_o` output 32: instruction presented to decode.
- `d_pc_o` output 32: PC of `d_inst_o`.
- `d_valid_o` output 1: `d_inst_o` is a real fetched instruction, not a bubble.

## Operation
- Reset values: `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `d_inst_o`=`NOP_INST` (32'h0000_0013), `d_pc_o`=0, `d_valid_o`=0. FIFO is empty, and the outstanding and drop counters are 0.
- Issue rule: `imem_req_o` = !`redirect_i` && (fifo_count + outstanding) < `FIFO_DEPTH`. Every response therefore has a guaranteed FIFO slot, so overflow cannot occur.
- `imem_addr_o` = `fetch_pc`. Address is stable while `imem_req_o`=1 and no grant has occurred. On req && gnt, `fetch_pc` += 4 (mod 2^32 wrap) and outstanding += 1.
- Response with drop_cnt=0: push {`rdata`, pc}. The FIFO tracks the PC of each entry. Outstanding -= 1.
- Response with drop_cnt>0: discard the word. drop_cnt -= 1 and outstanding -= 1.
- Decode register:
  - On `incr_pc_i`=1 with FIFO non-empty: pop the head into `d_inst_o`/`d_pc_o` and set `d_valid_o`=1.
  - On `incr_pc_i`=1 with FIFO empty: load `NOP_INST` and set `d_valid_o`=0. `d_pc_o` holds its value.
  - On `incr_pc_i`=0: all three outputs hold.
- Redirect has priority over everything.
  - `fetch_pc` is set to `redirect_pc_i` and the FIFO is cleared.
  - drop_cnt is set to outstanding minus any response consumed that same cycle.
  - The decode register is set to `NOP_INST` with `d_valid_o`=0.
  - `imem_req_o` is 0 in the redirect cycle.
- A push and a pop in the same cycle leave the FIFO count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- Reset asserted mid-operation returns every state element to its reset value immediately. Memory responses owed at that point are the memory's responsibility; the bench resets both together.

## Timing
- Grant at cycle N, response at N+1 (minimum). The response is pushed at the end of N+1.
  - Without bypass: visible on `d_inst_o` in cycle N+3 when `incr_pc_i`=1.
  - With `FETCH_BYPASS_EN`: visible in cycle N+2.
- Steady state with single-cycle memory: one valid instruction per cycle after the pipeline fills.
- Redirect at cycle R: first request to `redirect_pc_i` appears in cycle R+1.
- A stall (`incr_pc_i`=0) fills the FIFO within `FIFO_DEPTH` cycles, after which `imem_req_o` drops to 0.

## Configuration
- `FETCH_BYPASS_EN` defined: when the FIFO is empty, `imem_rvalid_i`=1, drop_cnt=0 and `incr_pc_i`=1, the response goes directly into the decode register without a FIFO push.
- `FETCH_BYPASS_EN` undefined: every response passes through the FIFO, adding one cycle of latency.
- Functional ordering is identical in both builds; only timing differs.

## Structure
- `proc_pkg` gains `NOP_INST` and `INST_W` = 32.
- The outstanding and drop counters use width $clog2(`FIFO_DEPTH`+1) and are declared locally.
- Sub-module `fetch_fifo`: synchronous FIFO of {inst, pc}.
  - Ports: push, pop, clear, count, empty, head data.
  - Clear has priority over push and pop.

## Test plan
- Reset, single-cycle memory, `incr_pc_i`=1 throughout: addresses 0,4,8,…, and `d_inst_o` sequence matches memory with `d_valid_o`=1 from cycle 3.
- `incr_pc_i`=0 for 5 cycles mid-stream: `d_inst_o` held; `imem_req_o`=0 once count+outstanding=2; no instruction lost or duplicated after release.
- Memory with 3-cycle response latency: NOP bubbles with `d_valid_o`=0 inserted between instructions; at most 2 outstanding requests.
- Redirect to 32'h0000_0100 with 2 requests outstanding: both late responses are dropped, the next valid `d_pc_o` is 32'h100, and the bubble is NOP.
- Grant withheld 4 cycles: `imem_addr_o` stable, PC advances only on grant.
- `RESET_PC`=32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; check the wrap and, in both macro builds, the latency difference of 1 cycle.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor types and constants.
// The fetch stage reads NOP_INST, INST_W and the fetch buffer entry type from here.
package proc_pkg;

  localparam int INST_W = 32;
  localparam int XLEN   = 32;

  // ADDI x0, x0, 0
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {inst, pc} entries; clear beats push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import proc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t data_i,
  output logic [CW-1:0] count_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i && !clear_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem request/grant/response, buffered decode register.
// Optional FETCH_BYPASS_EN lets a response skip the empty FIFO straight into decode.
module fetch_unit
  import proc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              incr_pc_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              imem_req_o,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [INST_W-1:0] d_inst_o,
  output logic [XLEN-1:0]   d_pc_o,
  output logic              d_valid_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [INST_W-1:0] d_inst_q, d_inst_d;
  logic [XLEN-1:0]   d_pc_q, d_pc_d;
  logic              d_valid_q, d_valid_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  fetch_entry_t      fifo_head;
  fetch_entry_t      fifo_in;
  logic [CW:0]       inflight;
  logic              grant;
  logic              rsp_drop;
  logic              rsp_take;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;

  // Only issue when every in-flight response is guaranteed a buffer slot.
  assign inflight   = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_o = rst_n_i && !redirect_i && (inflight < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign grant      = imem_req_o && imem_gnt_i;

  assign rsp_drop = imem_rvalid_i && (drop_q != '0);
  assign rsp_take = imem_rvalid_i && (drop_q == '0) && !redirect_i;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_take && fifo_empty && incr_pc_i;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = rsp_take && !bypass;
  assign fifo_pop  = incr_pc_i && !fifo_empty && !redirect_i;
  assign fifo_in   = '{inst: imem_rdata_i, pc: rsp_pc_q};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (redirect_i),
    .data_i  (fifo_in),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // rsp_pc tracks the address of the oldest response that will actually be kept.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
    drop_d        = drop_q;
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      rsp_pc_d   = word_align(redirect_pc_i);
      drop_d     = outstanding_q - CW'(imem_rvalid_i);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_take) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_comb begin
    d_inst_d  = d_inst_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    if (redirect_i) begin
      d_inst_d  = NOP_INST;
      d_valid_d = 1'b0;
    end else if (incr_pc_i) begin
      if (bypass) begin
        d_inst_d  = imem_rdata_i;
        d_pc_d    = rsp_pc_q;
        d_valid_d = 1'b1;
      end else if (!fifo_empty) begin
        d_inst_d  = fifo_head.inst;
        d_pc_d    = fifo_head.pc;
        d_valid_d = 1'b1;
      end else begin
        d_inst_d  = NOP_INST;
        d_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      d_inst_q      <= NOP_INST;
      d_pc_q        <= '0;
      d_valid_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      d_inst_q      <= d_inst_d;
      d_pc_q        <= d_pc_d;
      d_valid_q     <= d_valid_d;
    end
  end

  assign d_inst_o  = d_inst_q;
  assign d_pc_o    = d_pc_q;
  assign d_valid_o = d_valid_q;

endmodule
